// File: rtl/mem_sram_ctrl.sv
// Splits a 32-bit load/store into two 16-bit SRAM accesses (low half, then
// high half). The pipeline is stalled through ready until both halves finish.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [16:0] r_word;
    logic [15:0] r_wdata_hi;
    logic        r_is_write;

    logic        w_req;
    logic        w_last;
    logic [31:0] w_offset;
    logic [16:0] w_word;
    logic        w_unused_bits;

    assign w_req    = wr_en | rd_en;
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_offset = addr - BASE_ADDR;
    // Only 17 word-address bits reach the SRAM; higher bits wrap away.
    assign w_word        = w_offset[18:2];
    assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};

    assign ready = ((r_state == IDLE) && !w_req) || (r_state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_word      <= 17'd0;
            r_wdata_hi  <= 16'd0;
            r_is_write  <= 1'b0;
            rdata       <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 4'd0;
                    // SRAM pins are set up on this edge so LOW starts with them valid.
                    if (w_req) begin
                        r_state    <= LOW;
                        r_is_write <= wr_en;
                        r_word     <= w_word;
                        r_wdata_hi <= wdata[31:16];
                        sram_addr  <= {w_word, 1'b0};
                        sram_dq_oe <= wr_en;
                        sram_we_n  <= ~wr_en;
                        if (wr_en) begin
                            sram_dq_out <= wdata[15:0];
                        end
                    end
                end
                LOW: begin
                    if (w_last) begin
                        r_state   <= HIGH;
                        r_cnt     <= 4'd0;
                        sram_addr <= {r_word, 1'b1};
                        if (r_is_write) begin
                            sram_dq_out <= r_wdata_hi;
                        end else begin
                            rdata[15:0] <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (w_last) begin
                        r_state    <= DONE;
                        r_cnt      <= 4'd0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!r_is_write) begin
                            rdata[31:16] <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: a default-timing instance and a
// WAIT_CYCLES=1 instance share one small behavioural SRAM.
module tb_mem_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        memInit;

    logic        wrEn, rdEn;
    logic [31:0] addrIn, wdataIn;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        wrEn1, rdEn1;
    logic [31:0] addrIn1, wdataIn1;
    logic [31:0] rdata1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1, sram_we_n1;

    logic [15:0] mem [0:255];

    int checkCount = 0;
    int failCount  = 0;
    int latency;

    logic [17:0] logAddr  [1:20];
    logic [15:0] logDq    [1:20];
    logic        logWe    [1:20];
    logic        logOe    [1:20];
    logic [31:0] logRdata [1:20];

    mem_sram_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wrEn), .rd_en(rdEn), .addr(addrIn),
        .wdata(wdataIn), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wrEn1), .rd_en(rdEn1), .addr(addrIn1),
        .wdata(wdataIn1), .rdata(rdata1), .ready(ready1), .sram_addr(sram_addr1),
        .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write on a clock edge while we_n is low.
    assign sram_dq_in  = mem[sram_addr[7:0]];
    assign sram_dq_in1 = mem[sram_addr1[7:0]];
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Starts #1 after an edge with the DUT idle; logs each cycle until ready.
    task automatic applyStimulus(input logic wr, input logic rd,
                                 input logic [31:0] a, input logic [31:0] d);
        wrEn = wr; rdEn = rd; addrIn = a; wdataIn = d;
        #1;
        latency = 0;
        for (int c = 1; c <= 20; c++) begin
            if (latency == 0) begin
                logAddr[c]  = sram_addr;
                logDq[c]    = sram_dq_out;
                logWe[c]    = sram_we_n;
                logOe[c]    = sram_dq_oe;
                logRdata[c] = rdata;
                if (ready) latency = c;
                else begin
                    @(posedge clk); #2;
                end
            end
        end
        wrEn = 1'b0; rdEn = 1'b0;
        if (latency == 0) checkOutput("timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    logic       weAll, oeAny;
    logic [9:0] readyBits;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0; memInit = 1'b1;
        wrEn = 0; rdEn = 0; addrIn = 0; wdataIn = 0;
        wrEn1 = 0; rdEn1 = 0; addrIn1 = 0; wdataIn1 = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_weN",   32'(sram_we_n), 32'd1);
        checkOutput("rst_oe",    32'(sram_dq_oe), 32'd0);
        checkOutput("rst_addr",  32'(sram_addr), 32'd0);
        checkOutput("rst_dq",    32'(sram_dq_out), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        memInit = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Write 0xDEADBEEF at 1028 -> half-words 2 (low) and 3 (high)
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        checkOutput("wr_latency", 32'(latency), 32'd6);
        checkOutput("wr_c1_weN",  32'(logWe[1]), 32'd1);
        checkOutput("wr_c2_addr", 32'(logAddr[2]), 32'd2);
        checkOutput("wr_c3_addr", 32'(logAddr[3]), 32'd2);
        checkOutput("wr_c2_dq",   32'(logDq[2]), 32'h0000BEEF);
        checkOutput("wr_c2_weN",  32'(logWe[2]), 32'd0);
        checkOutput("wr_c3_oe",   32'(logOe[3]), 32'd1);
        checkOutput("wr_c4_addr", 32'(logAddr[4]), 32'd3);
        checkOutput("wr_c5_addr", 32'(logAddr[5]), 32'd3);
        checkOutput("wr_c5_dq",   32'(logDq[5]), 32'h0000DEAD);
        checkOutput("wr_c5_weN",  32'(logWe[5]), 32'd0);
        checkOutput("wr_c6_weN",  32'(logWe[6]), 32'd1);
        checkOutput("wr_c6_oe",   32'(logOe[6]), 32'd0);
        checkOutput("wr_rdata",   rdata, 32'd0);
        checkOutput("wr_mem2",    32'(mem[2]), 32'h0000BEEF);
        checkOutput("wr_mem3",    32'(mem[3]), 32'h0000DEAD);
        checkOutput("wr_idle_ready", 32'(ready), 32'd1);

        // Read it back
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'd0);
        checkOutput("rd_latency", 32'(latency), 32'd6);
        checkOutput("rd_c3_rdata", logRdata[3], 32'h00000000);
        checkOutput("rd_c4_rdata", logRdata[4], 32'h0000BEEF);
        checkOutput("rd_rdata",    rdata, 32'hDEADBEEF);
        weAll = 1'b1; oeAny = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            weAll = weAll & logWe[c];
            oeAny = oeAny | logOe[c];
        end
        checkOutput("rd_weN_high", 32'(weAll), 32'd1);
        checkOutput("rd_oe_low",   32'(oeAny), 32'd0);

        // Both requests: write wins, rdata untouched
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'h12345678);
        checkOutput("both_weN",  32'(logWe[2]), 32'd0);
        checkOutput("both_rdata", rdata, 32'hDEADBEEF);
        checkOutput("both_mem4", 32'(mem[4]), 32'h00005678);
        checkOutput("both_mem5", 32'(mem[5]), 32'h00001234);

        // Address below base wraps to the top of SRAM
        applyStimulus(1'b0, 1'b1, 32'd1020, 32'd0);
        checkOutput("wrap_low",  32'(logAddr[2]), 32'h0003FFFE);
        checkOutput("wrap_high", 32'(logAddr[4]), 32'h0003FFFF);

        // Reset during the HIGH phase of a write to 1036 (half-words 6/7)
        wrEn = 1'b1; addrIn = 32'd1036; wdataIn = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rstw_pre_addr", 32'(sram_addr), 32'd7);
        checkOutput("rstw_pre_weN",  32'(sram_we_n), 32'd0);
        rst = 1'b0; wrEn = 1'b0;
        #1;
        checkOutput("rstw_weN",   32'(sram_we_n), 32'd1);
        checkOutput("rstw_oe",    32'(sram_dq_oe), 32'd0);
        checkOutput("rstw_ready", 32'(ready), 32'd1);
        checkOutput("rstw_addr",  32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        checkOutput("rstw_mem6", 32'(mem[6]), 32'h0000F00D);
        checkOutput("rstw_mem7", 32'(mem[7]), 32'h00000000);
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 32'd1036, 32'd0);
        checkOutput("rstw_readback", rdata, 32'h0000F00D);

        // WAIT_CYCLES=1: request held continuously across two reads
        rdEn1 = 1'b1; addrIn1 = 32'd1028;
        #1;
        weAll = 1'b1; oeAny = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            readyBits[c-1] = ready1;
            logRdata[c]    = rdata1;
            weAll = weAll & sram_we_n1;
            oeAny = oeAny | sram_dq_oe1;
            if (c == 4) addrIn1 = 32'd1032;
            if (c == 8) rdEn1 = 1'b0;
            @(posedge clk); #2;
        end
        checkOutput("w1_ready_pattern", 32'(readyBits), 32'h00000388);
        checkOutput("w1_c3_rdata", logRdata[3], 32'h0000BEEF);
        checkOutput("w1_c4_rdata", logRdata[4], 32'hDEADBEEF);
        checkOutput("w1_c5_rdata", logRdata[5], 32'hDEADBEEF);
        checkOutput("w1_c7_rdata", logRdata[7], 32'hDEAD5678);
        checkOutput("w1_c8_rdata", logRdata[8], 32'h12345678);
        checkOutput("w1_weN_high", 32'(weAll), 32'd1);
        checkOutput("w1_oe_low",   32'(oeAny), 32'd0);
        checkOutput("w1_dq",       32'(sram_dq_out1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
